// File: rtl/snoop_responder_if.sv
// snoop_responder_if: signal bundle of snoop_responder
// bus_*      : broadcast coherence message in, snoop_ready back-pressure out
// lcl_*      : CPU-side state/tag write into the line table
// wb_*       : writeback request/address out, wb_ack in
// snoop_*    : per-message result (done pulse, hit, final state), proto_err
interface snoop_responder_if #(parameter int ADDR_W = 8);
    logic              bus_valid;
    logic [2:0]        bus_msg;
    logic [1:0]        bus_src;
    logic [ADDR_W-1:0] bus_addr;
    logic              snoop_ready;
    logic              lcl_we;
    logic [ADDR_W-1:0] lcl_addr;
    logic [1:0]        lcl_state;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_ack;
    logic              snoop_done;
    logic              snoop_hit;
    logic [1:0]        snoop_state;
    logic              proto_err;
    modport master (
        output bus_valid, bus_msg, bus_src, bus_addr, lcl_we, lcl_addr, lcl_state, wb_ack,
        input  snoop_ready, wb_req, wb_addr, snoop_done, snoop_hit, snoop_state, proto_err
    );
    modport slave (
        input  bus_valid, bus_msg, bus_src, bus_addr, lcl_we, lcl_addr, lcl_state, wb_ack,
        output snoop_ready, wb_req, wb_addr, snoop_done, snoop_hit, snoop_state, proto_err
    );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: bus-side MSI snoop controller with per-line state/tag table
// clk   : rising-edge clock
// reset : synchronous active-low reset
// bus   : snoop_responder_if.slave (bus message, local write, writeback, result)
module snoop_responder #(
    parameter logic [1:0] MY_ID  = 2'd0,
    parameter int         IDX_W  = 2,
    parameter int         ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    snoop_responder_if.slave bus
);
    localparam int N  = 1 << IDX_W;
    localparam int TW = ADDR_W - IDX_W;
    localparam logic [2:0] RM  = 3'b001;
    localparam logic [2:0] WM  = 3'b010;
    localparam logic [2:0] INV = 3'b011;
    typedef enum logic [1:0] {IDLE, LOOKUP, WB, DONE} state_t;
    state_t st, nxt;
    logic [N-1:0][1:0]    line_st;
    logic [N-1:0][TW-1:0] line_tag;
    logic [2:0]           msg_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           fin_q, fin;
    logic                 hit_q, err_q, hit, excl, err, accept;
    logic [IDX_W-1:0]     idx, lidx;
    always_comb begin
        idx    = addr_q[IDX_W-1:0];
        lidx   = bus.lcl_addr[IDX_W-1:0];
        hit    = line_st[idx] != 2'b00 && line_tag[idx] == addr_q[ADDR_W-1:IDX_W];
        excl   = hit && line_st[idx] == 2'b10;
        err    = excl && msg_q == INV;
        // final line state; for exclusive read/write miss it is applied at wb_ack
        fin    = !hit ? 2'b00 : msg_q == RM ? 2'b01 : err ? 2'b10 : 2'b00;
        accept = st == IDLE && bus.bus_valid && bus.bus_src != MY_ID && bus.bus_msg inside {RM, WM, INV};
        nxt    = st;
        case (st)
            IDLE:    nxt = accept ? LOOKUP : IDLE;
            LOOKUP:  nxt = excl && !err ? WB : DONE;
            WB:      nxt = bus.wb_ack ? DONE : WB;
            default: nxt = IDLE;
        endcase
        bus.snoop_ready = st == IDLE;
        bus.wb_req      = st == WB;
        bus.wb_addr     = st == WB ? addr_q : '0;
        bus.snoop_done  = st == DONE;
        bus.snoop_hit   = st == DONE && hit_q;
        bus.snoop_state = st == DONE ? fin_q : 2'b00;
        bus.proto_err   = st == DONE && err_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) st <= IDLE;
        else        st <= nxt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            line_st  <= '0;
            line_tag <= '0;
            msg_q    <= '0;
            addr_q   <= '0;
            fin_q    <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // local write lands at the acceptance edge, so LOOKUP sees it
            if (st == IDLE && bus.lcl_we) begin
                line_st[lidx]  <= bus.lcl_state;
                line_tag[lidx] <= bus.lcl_addr[ADDR_W-1:IDX_W];
            end
            if (accept) begin
                msg_q  <= bus.bus_msg;
                addr_q <= bus.bus_addr;
            end
            if (st == LOOKUP) begin
                fin_q <= fin;
                hit_q <= hit;
                err_q <= err;
                if (hit && nxt == DONE) line_st[idx] <= fin;
            end
            if (st == WB && bus.wb_ack) line_st[idx] <= fin_q;
        end
    end
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: vector table plus scoreboard bench for snoop_responder
module tb_snoop_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    snoop_responder_if #(.ADDR_W(8)) bus ();
    snoop_responder #(.MY_ID(2'd0), .IDX_W(2), .ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic       hit;
        logic [1:0] st;
        logic       err;
    } exp_t;
    typedef struct {
        logic       lw;
        logic       same;
        logic [7:0] la;
        logic [1:0] ls;
        logic [2:0] msg;
        logic [1:0] src;
        logic [7:0] addr;
        logic       acc;
        logic       wb;
        int         dly;
        logic       hit;
        logic [1:0] st;
        logic       err;
    } vec_t;
    exp_t sb[$];
    exp_t mon_e;
    vec_t v[18];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    // every snoop_done is matched against the oldest expectation pushed at send time
    always @(negedge clk) begin
        if (bus.snoop_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_hit", {31'd0, bus.snoop_hit}, {31'd0, mon_e.hit});
                chk("sb_state", {30'd0, bus.snoop_state}, {30'd0, mon_e.st});
                chk("sb_proto_err", {31'd0, bus.proto_err}, {31'd0, mon_e.err});
            end
        end
    end
    task automatic lwrite(input logic [7:0] a, input logic [1:0] s);
        bus.lcl_we = 1'b1;
        bus.lcl_addr = a;
        bus.lcl_state = s;
        tick();
        bus.lcl_we = 1'b0;
    endtask
    task automatic send(input logic [2:0] m, input logic [1:0] s, input logic [7:0] a,
                        input logic acc, input logic h, input logic [1:0] st, input logic er);
        bus.bus_valid = 1'b1;
        bus.bus_msg = m;
        bus.bus_src = s;
        bus.bus_addr = a;
        if (acc) sb.push_back('{h, st, er});
        tick();
        bus.bus_valid = 1'b0;
    endtask
    task automatic run_vec(input vec_t t);
        if (t.lw && !t.same) lwrite(t.la, t.ls);
        if (t.lw && t.same) begin
            bus.lcl_we = 1'b1;
            bus.lcl_addr = t.la;
            bus.lcl_state = t.ls;
        end
        send(t.msg, t.src, t.addr, t.acc, t.hit, t.st, t.err);
        bus.lcl_we = 1'b0;
        if (!t.acc) begin
            repeat (3) begin
                chk("drop_no_done", {31'd0, bus.snoop_done}, 32'd0);
                chk("drop_ready", {31'd0, bus.snoop_ready}, 32'd1);
                tick();
            end
        end else if (t.wb) begin
            tick();
            chk("wb_req_rise", {31'd0, bus.wb_req}, 32'd1);
            chk("wb_addr", {24'd0, bus.wb_addr}, {24'd0, t.addr});
            for (int i = 0; i < t.dly; i++) begin
                tick();
                chk("wb_req_hold", {31'd0, bus.wb_req}, 32'd1);
                chk("wb_addr_hold", {24'd0, bus.wb_addr}, {24'd0, t.addr});
                chk("wb_no_done", {31'd0, bus.snoop_done}, 32'd0);
            end
            bus.wb_ack = 1'b1;
            tick();
            bus.wb_ack = 1'b0;
            chk("wb_done", {31'd0, bus.snoop_done}, 32'd1);
            chk("wb_req_drop", {31'd0, bus.wb_req}, 32'd0);
            chk("ready_in_done", {31'd0, bus.snoop_ready}, 32'd0);
            tick();
        end else begin
            chk("lookup_no_done", {31'd0, bus.snoop_done}, 32'd0);
            tick();
            chk("done_latency", {31'd0, bus.snoop_done}, 32'd1);
            chk("no_wb_req", {31'd0, bus.wb_req}, 32'd0);
            chk("ready_in_done", {31'd0, bus.snoop_ready}, 32'd0);
            tick();
        end
        chk("ready_idle", {31'd0, bus.snoop_ready}, 32'd1);
    endtask
    initial begin
        bus.bus_valid = 1'b0;
        bus.bus_msg = 3'd0;
        bus.bus_src = 2'd0;
        bus.bus_addr = 8'd0;
        bus.lcl_we = 1'b0;
        bus.lcl_addr = 8'd0;
        bus.lcl_state = 2'd0;
        bus.wb_ack = 1'b0;
        v[0]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd1, 8'h00, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[1]  = '{1'b1, 1'b0, 8'h15, 2'b01, 3'd3, 2'd1, 8'h15, 1'b1, 1'b0, 0, 1'b1, 2'b00, 1'b0};
        v[2]  = '{1'b1, 1'b0, 8'h22, 2'b10, 3'd1, 2'd2, 8'h22, 1'b1, 1'b1, 5, 1'b1, 2'b01, 1'b0};
        v[3]  = '{1'b1, 1'b0, 8'h22, 2'b10, 3'd2, 2'd3, 8'h22, 1'b1, 1'b1, 2, 1'b1, 2'b00, 1'b0};
        v[4]  = '{1'b1, 1'b0, 8'h22, 2'b10, 3'd3, 2'd1, 8'h22, 1'b1, 1'b0, 0, 1'b1, 2'b10, 1'b1};
        v[5]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd3, 2'd1, 8'h22, 1'b1, 1'b0, 0, 1'b1, 2'b10, 1'b1};
        v[6]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd0, 8'h22, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[7]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd0, 2'd1, 8'h22, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[8]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd4, 2'd1, 8'h22, 1'b0, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[9]  = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd1, 8'h22, 1'b1, 1'b1, 0, 1'b1, 2'b01, 1'b0};
        v[10] = '{1'b1, 1'b0, 8'h21, 2'b01, 3'd1, 2'd2, 8'h25, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd2, 8'h21, 1'b1, 1'b0, 0, 1'b1, 2'b01, 1'b0};
        v[12] = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd2, 2'd1, 8'h21, 1'b1, 1'b0, 0, 1'b1, 2'b00, 1'b0};
        v[13] = '{1'b1, 1'b1, 8'h33, 2'b10, 3'd1, 2'd1, 8'h33, 1'b1, 1'b1, 3, 1'b1, 2'b01, 1'b0};
        v[14] = '{1'b1, 1'b0, 8'h13, 2'b10, 3'd1, 2'd1, 8'h33, 1'b1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
        v[15] = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd2, 8'h13, 1'b1, 1'b1, 1, 1'b1, 2'b01, 1'b0};
        v[16] = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 2'd3, 8'h13, 1'b1, 1'b0, 0, 1'b1, 2'b01, 1'b0};
        v[17] = '{1'b0, 1'b0, 8'h00, 2'b00, 3'd2, 2'd1, 8'h13, 1'b1, 1'b0, 0, 1'b1, 2'b00, 1'b0};
        repeat (3) tick();
        reset = 1'b1;
        chk("rst_ready", {31'd0, bus.snoop_ready}, 32'd1);
        chk("rst_wb_req", {31'd0, bus.wb_req}, 32'd0);
        chk("rst_wb_addr", {24'd0, bus.wb_addr}, 32'd0);
        chk("rst_done", {31'd0, bus.snoop_done}, 32'd0);
        chk("rst_hit", {31'd0, bus.snoop_hit}, 32'd0);
        chk("rst_state", {30'd0, bus.snoop_state}, 32'd0);
        chk("rst_proto_err", {31'd0, bus.proto_err}, 32'd0);
        for (int i = 0; i < 18; i++) run_vec(v[i]);
        // local writes while in WB must be dropped
        lwrite(8'h0A, 2'b10);
        send(3'd1, 2'd1, 8'h0A, 1'b1, 1'b1, 2'b01, 1'b0);
        tick();
        chk("wbx_req", {31'd0, bus.wb_req}, 32'd1);
        bus.lcl_we = 1'b1;
        bus.lcl_addr = 8'h0A;
        bus.lcl_state = 2'b00;
        tick();
        bus.lcl_addr = 8'h0E;
        bus.lcl_state = 2'b01;
        tick();
        bus.lcl_we = 1'b0;
        chk("wbx_req_hold", {31'd0, bus.wb_req}, 32'd1);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("wbx_done", {31'd0, bus.snoop_done}, 32'd1);
        tick();
        send(3'd1, 2'd2, 8'h0A, 1'b1, 1'b1, 2'b01, 1'b0);
        tick();
        chk("wbx_recheck_done", {31'd0, bus.snoop_done}, 32'd1);
        tick();
        // reset while a writeback is pending
        lwrite(8'h3F, 2'b10);
        send(3'd2, 2'd1, 8'h3F, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        chk("rwb_req", {31'd0, bus.wb_req}, 32'd1);
        reset = 1'b0;
        bus.wb_ack = 1'b1;
        sb.delete();
        tick();
        reset = 1'b1;
        bus.wb_ack = 1'b0;
        chk("rwb_req_low", {31'd0, bus.wb_req}, 32'd0);
        chk("rwb_wb_addr", {24'd0, bus.wb_addr}, 32'd0);
        chk("rwb_ready", {31'd0, bus.snoop_ready}, 32'd1);
        repeat (3) begin
            chk("rwb_no_done", {31'd0, bus.snoop_done}, 32'd0);
            tick();
        end
        send(3'd1, 2'd1, 8'h3F, 1'b1, 1'b0, 2'b00, 1'b0);
        tick();
        chk("rwb_miss3_done", {31'd0, bus.snoop_done}, 32'd1);
        tick();
        send(3'd1, 2'd2, 8'h0A, 1'b1, 1'b0, 2'b00, 1'b0);
        tick();
        chk("rwb_miss2_done", {31'd0, bus.snoop_done}, 32'd1);
        tick();
        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
Bus-side half of the per-processor MSI snooping cache controller. It watches coherence messages that other processors broadcast (read miss, write miss, invalidate) and downgrades or invalidates the local copy of the addressed block. When the local copy is exclusive (dirty), it requests a writeback. It also holds the per-line state/tag table, which the CPU-side controller updates through a local write port.

Parameters:
MY_ID, 2'd0, processor index of this cache; bus messages with bus_src == MY_ID are ignored
IDX_W, 2, line index width; table depth = 2**IDX_W lines
ADDR_W, 8, block address width; tag = addr[ADDR_W-1:IDX_W]

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
bus_valid  input  1  bus message present this cycle
bus_msg  input  3  3'b001 read miss, 3'b010 write miss, 3'b011 invalidate, others ignored
bus_src  input  2  index of processor that issued the message
bus_addr  input  ADDR_W  block address of message
snoop_ready  output  1  high only in IDLE; a message is accepted only when bus_valid && snoop_ready
lcl_we  input  1  CPU-side state/tag write
lcl_addr  input  ADDR_W  block address for local write
lcl_state  input  2  new state: 2'b00 invalid, 2'b01 shared, 2'b10 exclusive
wb_req  output  1  writeback request, held until wb_ack
wb_addr  output  ADDR_W  block to write back, stable while wb_req
wb_ack  input  1  memory accepted writeback
snoop_done  output  1  one-cycle pulse at end of every accepted message
snoop_hit  output  1  valid with snoop_done: tag matched and state != invalid
snoop_state  output  2  valid with snoop_done: line state after the message
proto_err  output  1  one-cycle pulse with snoop_done on invalidate hitting an exclusive line

Behaviour:
- Reset (reset==0 at clk edge): all line states 2'b00, tags 0, FSM to IDLE. All outputs 0 except snoop_ready=1. Reset overrides every other event, including a pending writeback: wb_req is 0 the cycle after reset, and no table update happens.
- FSM states: IDLE, LOOKUP, WB, DONE.
- IDLE: a message is accepted when bus_valid && snoop_ready && bus_src != MY_ID && bus_msg in {001,010,011}. Latch msg/addr, go to LOOKUP. Any other message is dropped with no response.
- LOOKUP (1 cycle): idx = addr[IDX_W-1:0]. hit = (state[idx] != 00) && (tag[idx] == addr tag).
  - Miss: no change, go to DONE, snoop_state = 00.
  - Shared + read miss: stays shared, go to DONE.
  - Shared + write miss or invalidate: set invalid, go to DONE.
  - Exclusive + read miss: go to WB; final state shared.
  - Exclusive + write miss: go to WB; final state invalid.
  - Exclusive + invalidate: state unchanged, proto_err, go to DONE.
- WB: wb_req=1 and wb_addr=latched addr, asserted on the cycle after LOOKUP. Wait indefinitely. On the wb_ack cycle, write the final state to the table, drop wb_req next cycle, go to DONE. A wb_ack outside WB is ignored.
- DONE (1 cycle): snoop_done=1 with snoop_hit/snoop_state/proto_err, then IDLE.
- Latency: non-writeback message done 2 cycles after acceptance; writeback message done 1 cycle after wb_ack.
- Local write: applied only in IDLE (writes tag and state at lcl_addr's index). Ignored in other states; the CPU side must retry. A local write and a bus acceptance in the same IDLE cycle are both taken. The local write lands first, and LOOKUP sees the updated line.
- Back-to-back: the next message can be accepted on the first IDLE cycle after DONE.

Test Plan:
- Reset then local write addr 8'h15 state 01; invalidate from src 1 addr 8'h15 -> done 2 cycles later, hit=1, state=00.
- Local write 8'h22 state 10; read miss src 2 addr 8'h22 -> wb_req=1, wb_addr=8'h22 held 5 cycles until wb_ack; done next cycle, state=01.
- Line exclusive, write miss src 3 with the same address -> writeback then state=00. Invalidate on an exclusive line -> proto_err=1, state stays 10.
- Message with bus_src==MY_ID, or bus_msg=3'b000 -> no snoop_done, table unchanged. Tag mismatch (addr 8'h25 vs stored 8'h21) -> hit=0, line unchanged.
- Local write and read miss in the same cycle on a line going to exclusive -> writeback path is taken. lcl_we during WB is ignored.
- reset low while in WB -> wb_req=0 next cycle, all lines invalid, no snoop_done.
